sd_block_read_controller: RTL

Sequences a single-block SD read (CMD17) across the SD command sender and the SD SPI receiver. It programs the receiver's response type, validates the R1 response, captures the 4096-bit data block, and retries on CRC error or timeout. It sits between the SD controller's host-side read request logic and the SPI transmit/receive datapaths.

---
 rtl/sd_block_read_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sd_block_read_controller.sv
// Single-block SD read (CMD17) sequencer: issues the command, checks R1,
// captures the data block and retries on CRC error or timeout.
module sd_block_read_controller #(
   parameter int unsigned RETRY_MAX      = 3,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          rd_en,
   input  logic [31:0]   addr,
   output logic          busy,
   output logic          rd_done,
   output logic          rd_error,
   output logic [1:0]    rd_error_code,
   output logic [4095:0] read_block,
   output logic          cmd_valid,
   output logic [5:0]    cmd_index,
   output logic [31:0]   cmd_argument,
   input  logic          sender_ready,
   output logic [1:0]    response_type,
   output logic          new_response_type,
   input  logic [4095:0] received_data,
   input  logic          data_valid,
   input  logic          crc_error
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_WAITR1, S_WAITDATA, S_DONE, S_ERROR
   } state_t;

   localparam logic [15:0] TMO  = 16'(TIMEOUT_CYCLES);
   localparam logic [7:0]  RMAX = 8'(RETRY_MAX);

   state_t          state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [7:0]      retry_q, retry_d;
   logic [15:0]     tmo_q, tmo_d;
   logic            armed_q, armed_d;
   logic [1:0]      code_q, code_d;
   logic [4095:0]   block_q, block_d;

   logic            dv_arm, crc_arm, tmo_hit, r1_ok;
   logic            fail;
   logic [1:0]      fail_code;

   assign dv_arm  = armed_q & data_valid;
   assign crc_arm = armed_q & crc_error;
   assign tmo_hit = (tmo_q == TMO);
   assign r1_ok   = (received_data[7:0] == 8'h00);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         retry_q <= '0;
         tmo_q   <= '0;
         armed_q <= 1'b0;
         code_q  <= '0;
         block_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         retry_q <= retry_d;
         tmo_q   <= tmo_d;
         armed_q <= armed_d;
         code_q  <= code_d;
         block_q <= block_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      retry_d   = retry_q;
      tmo_d     = tmo_q;
      armed_d   = armed_q;
      code_d    = code_q;
      block_d   = block_q;
      fail      = 1'b0;
      fail_code = 2'b00;
      // Status left high from the previous frame must drop before it counts.
      if (state_q == S_WAITR1 || state_q == S_WAITDATA) begin
         if (!data_valid) armed_d = 1'b1;
         if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
      end
      unique case (state_q)
         S_IDLE: begin
            if (rd_en) begin
               addr_d  = addr;
               retry_d = '0;
               code_d  = 2'b00;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (sender_ready) begin
               armed_d = 1'b0;
               tmo_d   = '0;
               state_d = S_WAITR1;
            end
         end
         S_WAITR1: begin
            if (dv_arm) begin
               if (r1_ok) begin
                  armed_d = 1'b0;
                  tmo_d   = '0;
                  state_d = S_WAITDATA;
               end else begin
                  code_d  = 2'b01;
                  state_d = S_ERROR;
               end
            end else if (tmo_hit) begin
               fail      = 1'b1;
               fail_code = 2'b11;
            end
         end
         S_WAITDATA: begin
            if (crc_arm) begin
               fail      = 1'b1;
               fail_code = 2'b10;
            end else if (dv_arm) begin
               block_d = received_data;
               state_d = S_DONE;
            end else if (tmo_hit) begin
               fail      = 1'b1;
               fail_code = 2'b11;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (fail) begin
         if (retry_q < RMAX) begin
            retry_d = retry_q + 8'd1;
            state_d = S_SEND;
         end else begin
            code_d  = fail_code;
            state_d = S_ERROR;
         end
      end
   end

   always_comb begin
      busy              = (state_q != S_IDLE);
      rd_done           = 1'b0;
      rd_error          = 1'b0;
      cmd_valid         = 1'b0;
      cmd_index         = '0;
      cmd_argument      = '0;
      response_type     = 2'b00;
      new_response_type = 1'b0;
      unique case (state_q)
         S_SEND: begin
            cmd_valid         = 1'b1;
            cmd_index         = 6'd17;
            cmd_argument      = addr_q;
            new_response_type = sender_ready;
         end
         S_WAITR1: begin
            if (dv_arm && r1_ok) begin
               response_type     = 2'b10;
               new_response_type = 1'b1;
            end
         end
         S_DONE:  rd_done  = 1'b1;
         S_ERROR: rd_error = 1'b1;
         default: ;
      endcase
   end

   assign rd_error_code = code_q;
   assign read_block    = block_q;

endmodule
